fb_block_renderer: RTL and testbench

//   Raster renderer that sits directly upstream of ddr3_framebuffer. It drives the write port
//   (fb_vsync/fb_we/fb_data) with a paced, full-frame scan: a moving BLOCK_CELLS x BLOCK_CELLS

---
 rtl/fb_block_renderer.sv | 170 +++++++++++++++++
 tb/tb_fb_block_renderer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fb_block_renderer.sv
// rtl/fb_block_renderer.sv - paced full-frame raster writer: moving cell block over a colour-cycling background
// Optional build macro FB_RENDER_CHECKER_EN selects a checkerboard background.
module fb_block_renderer #(
    parameter int                    WIDTH        = 640,
    parameter int                    HEIGHT       = 480,
    parameter int                    COLOR_BITS   = 18,
    parameter int                    PIXEL_PERIOD = 4,
    parameter int                    BLOCK_CELLS  = 4,
    parameter logic [COLOR_BITS-1:0] FG_COLOR     = 'h00FC0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  fb_vsync,
    output logic                  fb_we,
    output logic [COLOR_BITS-1:0] fb_data,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);

    localparam int              PW           = (PIXEL_PERIOD > 2) ? $clog2(PIXEL_PERIOD) : 1;
    localparam logic [PW-1:0]   PACE_LOAD    = PW'(PIXEL_PERIOD - 1);
    localparam logic [13:0]     X_LAST       = 14'(WIDTH - 1);
    localparam logic [13:0]     Y_LAST       = 14'(HEIGHT - 1);
    localparam logic [11:0]     CELLS_X_LAST = 12'(WIDTH / 8 - 1);
    localparam logic [11:0]     CELLS_Y      = 12'(HEIGHT / 8);
    localparam logic [11:0]     BLK          = 12'(BLOCK_CELLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VSYNC = 2'd1,
        S_PIXEL = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] pace;
    logic [13:0]   x;
    logic [13:0]   y;
    logic [10:0]   cur_x;
    logic [10:0]   cur_y;
    logic [5:0]    bg_r;
    logic [5:0]    bg_g;
    logic [5:0]    bg_b;
    // Snapshot taken at each vsync: the frame being drawn uses these, updates show next frame.
    logic [10:0]   frm_x;
    logic [10:0]   frm_y;
    logic [17:0]   frm_bg;

    logic                  tick;
    logic [10:0]           cell_x;
    logic [10:0]           cell_y;
    logic                  in_blk;
    logic [17:0]           bg_pix;
    logic [COLOR_BITS-1:0] pix;
    logic [11:0]           cy_adv;
    logic [10:0]           next_cx;
    logic [10:0]           next_cy;

    assign tick   = (pace == '0);
    assign cell_x = x[13:3];
    assign cell_y = y[13:3];

    // 12-bit upper bounds so cursor+BLOCK_CELLS never wraps before the compare.
    assign in_blk = ({1'b0, cell_x} >= {1'b0, frm_x}) && ({1'b0, cell_x} < ({1'b0, frm_x} + BLK)) &&
                    ({1'b0, cell_y} >= {1'b0, frm_y}) && ({1'b0, cell_y} < ({1'b0, frm_y} + BLK));

`ifdef FB_RENDER_CHECKER_EN
    assign bg_pix = (cell_x[0] ^ cell_y[0]) ? ~frm_bg : frm_bg;
`else
    assign bg_pix = frm_bg;
`endif

    assign pix = in_blk ? FG_COLOR : COLOR_BITS'(bg_pix);

    always_comb begin
        cy_adv  = {1'b0, cur_y} + BLK;
        next_cx = cur_x + 11'd1;
        next_cy = cur_y;
        if ({1'b0, cur_x} == CELLS_X_LAST) begin
            next_cx = '0;
            next_cy = ((cy_adv + BLK) > CELLS_Y) ? 11'd0 : cy_adv[10:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pace      <= '0;
            x         <= '0;
            y         <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            bg_r      <= 6'd0;
            bg_g      <= 6'd63;
            bg_b      <= 6'd32;
            frm_x     <= '0;
            frm_y     <= '0;
            frm_bg    <= {6'd0, 6'd63, 6'd32};
            fb_vsync  <= 1'b0;
            fb_we     <= 1'b0;
            fb_data   <= '0;
            frame_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            fb_vsync <= 1'b0;
            fb_we    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_VSYNC;
                        busy  <= 1'b1;
                        pace  <= PACE_LOAD;
                    end
                end
                S_VSYNC: begin
                    if (tick) begin
                        fb_vsync  <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        frm_x     <= cur_x;
                        frm_y     <= cur_y;
                        frm_bg    <= {bg_r, bg_g, bg_b};
                        cur_x     <= next_cx;
                        cur_y     <= next_cy;
                        if (frame_cnt[3:0] == 4'd0) begin
                            bg_r <= bg_r + 6'd1;
                            bg_g <= bg_g + 6'd2;
                            bg_b <= bg_b + 6'd3;
                        end
                        x     <= '0;
                        y     <= '0;
                        pace  <= PACE_LOAD;
                        state <= S_PIXEL;
                    end else begin
                        pace <= pace - 1'b1;
                    end
                end
                S_PIXEL: begin
                    if (tick) begin
                        fb_we   <= 1'b1;
                        fb_data <= pix;
                        pace    <= PACE_LOAD;
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y <= '0;
                                if (enable) begin
                                    state <= S_VSYNC;
                                end else begin
                                    state <= S_IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                y <= y + 14'd1;
                            end
                        end else begin
                            x <= x + 14'd1;
                        end
                    end else begin
                        pace <= pace - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_block_renderer.sv
// tb/tb_fb_block_renderer.sv - directed bench for fb_block_renderer at 16x16, two clocks per pixel
module tb_fb_block_renderer;

    localparam int          W   = 16;
    localparam int          H   = 16;
    localparam int          PP  = 2;
    localparam int          BC  = 1;
    localparam logic [17:0] FG  = 18'h00FC0;
    localparam logic [17:0] BG0 = 18'h00FE0;
    localparam logic [17:0] BG1 = 18'h01063;
    localparam logic [17:0] BG2 = 18'h020E6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fb_vsync;
    logic        fb_we;
    logic [17:0] fb_data;
    logic [15:0] frame_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int coinc    = 0;

    always #5 clk = ~clk;

    fb_block_renderer #(
        .WIDTH(W), .HEIGHT(H), .COLOR_BITS(18), .PIXEL_PERIOD(PP), .BLOCK_CELLS(BC), .FG_COLOR(FG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fb_vsync(fb_vsync), .fb_we(fb_we),
        .fb_data(fb_data), .frame_cnt(frame_cnt), .busy(busy)
    );

    always @(negedge clk) if (fb_we && fb_vsync) coinc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pix_model(input int x, input int y, input int cx, input int cy,
                                              input logic [17:0] bg);
        int bx;
        int by;
        bx = x / 8;
        by = y / 8;
        if (bx >= cx && bx < cx + BC && by >= cy && by < cy + BC) return FG;
`ifdef FB_RENDER_CHECKER_EN
        if (((bx ^ by) & 1) == 1) return ~bg;
`endif
        return bg;
    endfunction

    task automatic wait_vsync(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fb_vsync && n < 50);
        if (!fb_vsync) n = -1;
    endtask

    // Starts at a vsync negedge; scans one frame window, ends at the next vsync or after 600 clks.
    task automatic run_frame(input int cx, input int cy, input logic [17:0] bg, input int drop_at,
                             output int we_cnt, output int bad, output int len, output int dly,
                             output logic [17:0] first, output logic [17:0] px8);
        logic [17:0] held;
        int          n;
        we_cnt = 0; bad = 0; len = -1; dly = -1; first = '0; px8 = '0; held = fb_data; n = 0;
        while (n < 600) begin
            @(negedge clk);
            n++;
            if (fb_we) begin
                if (we_cnt == 0) begin
                    dly   = n;
                    first = fb_data;
                end
                if (we_cnt == 8) px8 = fb_data;
                if (fb_data !== pix_model(we_cnt % W, we_cnt / W, cx, cy, bg)) bad++;
                held = fb_data;
                we_cnt++;
                if (we_cnt == drop_at) enable = 1'b0;
            end else if (fb_data !== held) begin
                bad++;
            end
            if (fb_vsync) begin
                len = n;
                break;
            end
        end
    endtask

    initial begin
        int          n;
        int          we_cnt;
        int          bad;
        int          len;
        int          dly;
        logic [17:0] first;
        logic [17:0] px8;
        logic [17:0] bgk;

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vsync", fb_vsync, 0);
        check("rst_we", fb_we, 0);
        check("rst_data", fb_data, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_vsync", fb_vsync, 0);

        enable = 1'b1;
        wait_vsync(n);
        check("first_vsync_latency", n, PP + 1);
        check("first_frame_cnt", frame_cnt, 1);
        check("run_busy", busy, 1);

        for (int k = 1; k <= 17; k++) begin
            bgk = (k == 1) ? BG0 : BG1;
            run_frame((k - 1) % 2, ((k - 1) / 2) % 2, bgk, -1, we_cnt, bad, len, dly, first, px8);
            check($sformatf("f%0d_we_count", k), we_cnt, W * H);
            check($sformatf("f%0d_pixels", k), bad, 0);
            check($sformatf("f%0d_length", k), len, (W * H + 1) * PP);
            check($sformatf("f%0d_frame_cnt", k), frame_cnt, k + 1);
            if (k == 1) begin
                check("f1_first_we_delay", dly, PP);
                check("f1_pixel_0_0", first, FG);
`ifdef FB_RENDER_CHECKER_EN
                check("f1_pixel_8_0", px8, ~BG0);
`else
                check("f1_pixel_8_0", px8, BG0);
`endif
            end
            if (k == 2) check("f2_pixel_0_0", first, BG1);
            if (k == 5) check("f5_pixel_0_0", first, FG);
        end

        run_frame(1, 0, BG2, 100, we_cnt, bad, len, dly, first, px8);
        check("drop_we_count", we_cnt, W * H);
        check("drop_pixels", bad, 0);
        check("drop_no_vsync", len, -1);
        check("drop_pixel_0_0", first, BG2);
        check("drop_busy", busy, 0);
        check("drop_frame_cnt", frame_cnt, 18);

        enable = 1'b1;
        wait_vsync(n);
        check("restart_latency", n, PP + 1);
        check("restart_frame_cnt", frame_cnt, 19);
        repeat (40) @(negedge clk);
        n = 0;
        while (!fb_we && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_we", fb_we, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", fb_we, 0);
        check("async_rst_vsync", fb_vsync, 0);
        check("async_rst_data", fb_data, 0);
        check("async_rst_frame_cnt", frame_cnt, 0);
        check("async_rst_busy", busy, 0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_vsync(n);
        check("post_reset_latency", n, PP + 1);
        check("post_reset_frame_cnt", frame_cnt, 1);
        run_frame(0, 0, BG0, 10, we_cnt, bad, len, dly, first, px8);
        check("post_reset_pixel_0_0", first, FG);
        check("post_reset_pixels", bad, 0);
        check("post_reset_we_count", we_cnt, W * H);
        check("post_reset_no_vsync", len, -1);
        check("post_reset_busy", busy, 0);

        check("vsync_we_overlap", coinc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
